seg_scan_mux: RTL and testbench

Multiplexed scan controller for a common-anode, four-digit hex display. It holds a double-buffered 16-bit display value and time-multiplexes one nibble at a time onto the 4-bit input of the downstream hex-to-segment decoder. It also drives the matching active-low digit anodes. Updates are tear-free: they take effect only at frame boundaries. A blanking gap between digits prevents ghosting.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_scan_mux_if.sv | 32 +++
 rtl/scan_timer.sv | 42 ++++
 rtl/seg_scan_mux.sv | 141 ++++++++++++++
 tb/tb_seg_scan_mux.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg : shared types and constants for the seg_scan_mux display scanner
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } seg_state_t;

  localparam int   SEG_DIGIT_W = 4;
  // Anodes are active-low: a 1 keeps the digit dark.
  localparam logic SEG_AN_OFF  = 1'b1;

  function automatic int seg_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_scan_mux_if.sv
// -----------------------------------------------------------------------------
// seg_scan_mux_if : load/value/ack bus plus decoder and anode outputs
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  import seg_pkg::*;

  logic                              load;
  logic [SEG_DIGIT_W*NUM_DIGITS-1:0] value;
  logic                              lz_blank;
  logic                              ack;
  logic                              frame_start;
  logic [SEG_DIGIT_W-1:0]            nibble;
  logic [NUM_DIGITS-1:0]             an;

  modport master (
    output load, value, lz_blank,
    input  ack, frame_start, nibble, an
  );

  modport slave (
    input  load, value, lz_blank,
    output ack, frame_start, nibble, an
  );

endinterface

`default_nettype wire

// File: rtl/scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer : loadable down-counter, tc_o flags the last cycle of a slot
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module scan_timer #(
  parameter int                CNT_W   = 3,
  parameter logic [CNT_W-1:0]  RST_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load_i,
  input  wire logic [CNT_W-1:0] load_val_i,
  output logic                  tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of 1 is the final cycle; 0 also counts so a zero load cannot stall.
  assign tc_o = (cnt_q <= CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seg_scan_mux : double-buffered, tear-free multiplexed hex display scanner
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_CYCLES   = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  seg_scan_mux_if.slave  scan_if
);

  localparam int c_VAL_W = SEG_DIGIT_W * NUM_DIGITS;
  localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_CNT_W = $clog2(seg_max(DIV_CYCLES, BLANK_CYCLES) + 1);

  localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(NUM_DIGITS - 1);
  localparam logic [c_CNT_W-1:0] c_DIV_LD    = c_CNT_W'(DIV_CYCLES);
  localparam logic [c_CNT_W-1:0] c_BLANK_LD  = c_CNT_W'(BLANK_CYCLES);
  // With blanking disabled the scan starts straight in the digit-0 drive slot.
  localparam seg_state_t         c_RST_STATE = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
  localparam logic [c_CNT_W-1:0] c_RST_CNT   = (BLANK_CYCLES == 0) ? c_DIV_LD : c_BLANK_LD;

  seg_state_t             state_q, state_d;
  logic [c_IDX_W-1:0]     idx_q, idx_d;
  logic [c_VAL_W-1:0]     pending_q, pending_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [c_VAL_W-1:0]     disp_q, disp_d;
  logic [NUM_DIGITS-1:0]  an_q, an_d;
  logic [SEG_DIGIT_W-1:0] nibble_q, nibble_d;
  logic                   ack_q, ack_d;
  logic                   frame_start_q, frame_start_d;

  logic                   tc;
  logic                   commit;
  logic [c_CNT_W-1:0]     tmr_val;
  logic [NUM_DIGITS-1:0]  lz_dark;

  scan_timer #(
    .CNT_W   (c_CNT_W),
    .RST_VAL (c_RST_CNT)
  ) u_scan_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tc),
    .load_val_i (tmr_val),
    .tc_o       (tc)
  );

  // Digit i>0 is dark when it and every more significant nibble are zero.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
    if (i == 0) begin : g_first
      assign lz_dark[i] = 1'b0;
    end else begin : g_upper
      assign lz_dark[i] = scan_if.lz_blank && (disp_q[c_VAL_W-1:SEG_DIGIT_W*i] == '0);
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    disp_d        = disp_q;
    pending_d     = pending_q;
    pend_valid_d  = pend_valid_q;
    ack_d         = 1'b0;
    frame_start_d = 1'b0;
    commit        = 1'b0;

    if (tc) begin
      if (state_q == ST_BLANK) begin
        state_d = ST_DRIVE;
      end else begin
        state_d = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
        if (idx_q == c_LAST_IDX) begin
          idx_d         = '0;
          frame_start_d = 1'b1;
          commit        = pend_valid_q;
        end else begin
          idx_d = idx_q + c_IDX_W'(1);
        end
      end
    end

    if (commit) begin
      disp_d       = pending_q;
      pend_valid_d = 1'b0;
      ack_d        = 1'b1;
    end

    // A load on the commit cycle refills the buffer after the old value left it.
    if (scan_if.load) begin
      pending_d    = scan_if.value;
      pend_valid_d = 1'b1;
    end

    tmr_val  = (state_d == ST_DRIVE) ? c_DIV_LD : c_BLANK_LD;
    nibble_d = disp_d[SEG_DIGIT_W*idx_d +: SEG_DIGIT_W];
    an_d     = {NUM_DIGITS{SEG_AN_OFF}};
    if ((state_d == ST_DRIVE) && !lz_dark[idx_d]) begin
      an_d[idx_d] = ~SEG_AN_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= c_RST_STATE;
      idx_q         <= '0;
      pending_q     <= '0;
      pend_valid_q  <= 1'b0;
      disp_q        <= '0;
      an_q          <= {NUM_DIGITS{SEG_AN_OFF}};
      nibble_q      <= '0;
      ack_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      pend_valid_q  <= pend_valid_d;
      disp_q        <= disp_d;
      an_q          <= an_d;
      nibble_q      <= nibble_d;
      ack_q         <= ack_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign scan_if.an          = an_q;
  assign scan_if.nibble      = nibble_q;
  assign scan_if.ack         = ack_q;
  assign scan_if.frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_mux : directed bench for seg_scan_mux (N=4, DIV=4, BLANK=2)
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_mux;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   ack_cnt;
  logic [3:0] an_low;

  seg_scan_mux_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_mux #(
    .NUM_DIGITS   (4),
    .DIV_CYCLES   (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scan_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running tallies of ack pulses and of every anode that has been driven low.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (bus.ack) ack_cnt++;
      an_low = an_low | ~bus.an;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus.load = 1'b0;
    repeat (2) @(negedge clk);
    ack_cnt = 0;
    an_low  = '0;
    rst_n   = 1'b1;
  endtask

  logic [15:0] v;
  logic [3:0]  e_an;

  initial begin
    checks   = 0;
    failures = 0;
    ack_cnt  = 0;
    an_low   = '0;
    rst_n    = 1'b0;
    bus.load     = 1'b0;
    bus.value    = '0;
    bus.lz_blank = 1'b0;

    // Reset values, then basic commit of 1A3F loaded one cycle after release.
    step(2);
    check("rst_an",    bus.an, 4'b1111);
    check("rst_nib",   bus.nibble, 4'h0);
    check("rst_ack",   bus.ack, 1'b0);
    check("rst_frame", bus.frame_start, 1'b0);
    rst_n = 1'b1;
    step(1);
    check("post_rst_blank", bus.an, 4'b1111);
    bus.load = 1'b1; bus.value = 16'h1A3F;
    step(1);
    bus.load = 1'b0;
    check("first_drive_an",  bus.an, 4'b1110);
    check("first_drive_nib", bus.nibble, 4'h0);
    step(21);
    check("pre_commit_acks", ack_cnt, 0);
    check("pre_commit_an",   bus.an, 4'b0111);
    step(1);
    check("commit_ack",   bus.ack, 1'b1);
    check("commit_frame", bus.frame_start, 1'b1);
    check("commit_an",    bus.an, 4'b1111);
    check("commit_nib",   bus.nibble, 4'hF);
    step(1);
    check("ack_one_cycle",   bus.ack, 1'b0);
    check("frame_one_cycle", bus.frame_start, 1'b0);
    v = 16'h1A3F;
    for (int d = 0; d < 4; d++) begin
      e_an = ~(4'b0001 << d);
      for (int j = 0; j < 4; j++) begin
        step(1);
        check("seq_an",  bus.an, e_an);
        check("seq_nib", bus.nibble, v[4*d +: 4]);
      end
      if (d < 3) begin
        repeat (2) begin
          step(1);
          check("seq_blank", bus.an, 4'b1111);
        end
      end
    end
    step(1);
    check("no_second_ack", bus.ack, 1'b0);
    check("basic_acks",    ack_cnt, 1);

    // Asynchronous reset in the middle of the digit-2 drive slot.
    step(14);
    check("pre_async_an",  bus.an, 4'b1011);
    check("pre_async_nib", bus.nibble, 4'hA);
    #2 rst_n = 1'b0;
    #1;
    check("async_an",  bus.an, 4'b1111);
    check("async_nib", bus.nibble, 4'h0);
    check("async_ack", bus.ack, 1'b0);
    repeat (2) @(negedge clk);
    ack_cnt = 0;
    rst_n   = 1'b1;
    step(1);
    check("rel_blank", bus.an, 4'b1111);
    step(1);
    check("rel_drive", bus.an, 4'b1110);

    // Back-to-back loads in one frame: one ack, latest value shown.
    do_reset();
    step(2);
    bus.load = 1'b1; bus.value = 16'h1111;
    step(1);
    bus.value = 16'h2222;
    step(1);
    bus.load = 1'b0;
    step(22);
    check("b2b_nib",  bus.nibble, 4'h2);
    check("b2b_an",   bus.an, 4'b1110);
    check("b2b_acks", ack_cnt, 1);
    step(22);
    check("b2b_acks_later", ack_cnt, 1);
    check("b2b_nib_later",  bus.nibble, 4'h2);

    // Load coinciding with the commit cycle.
    do_reset();
    step(2);
    bus.load = 1'b1; bus.value = 16'h00AA;
    step(1);
    bus.load = 1'b0;
    step(20);
    bus.load = 1'b1; bus.value = 16'h00BB;
    step(1);
    bus.load = 1'b0;
    check("cc_ack1", bus.ack, 1'b1);
    check("cc_nib1", bus.nibble, 4'hA);
    step(2);
    check("cc_drive_nib1", bus.nibble, 4'hA);
    step(22);
    check("cc_ack2", bus.ack, 1'b1);
    check("cc_nib2", bus.nibble, 4'hB);
    step(2);
    check("cc_drive_nib2", bus.nibble, 4'hB);
    check("cc_drive_an2",  bus.an, 4'b1110);
    check("cc_acks",       ack_cnt, 2);

    // Leading-zero suppression: 0000, then 0005, then 0500.
    do_reset();
    bus.lz_blank = 1'b1;
    step(1);
    an_low = '0;
    step(1);
    check("lz0_an",  bus.an, 4'b1110);
    check("lz0_nib", bus.nibble, 4'h0);
    bus.load = 1'b1; bus.value = 16'h0005;
    step(1);
    bus.load = 1'b0;
    step(20);
    check("lz0000_mask", an_low, 4'b0001);
    step(1);
    an_low = '0;
    step(24);
    check("lz0005_mask", an_low, 4'b0001);
    bus.load = 1'b1; bus.value = 16'h0500;
    step(1);
    bus.load = 1'b0;
    step(23);
    an_low = '0;
    step(14);
    check("lz0500_d2_an",  bus.an, 4'b1011);
    check("lz0500_d2_nib", bus.nibble, 4'h5);
    step(10);
    check("lz0500_mask", an_low, 4'b0111);
    bus.lz_blank = 1'b0;

    // Reset with a pending value: no ack, display stays 0.
    do_reset();
    step(2);
    bus.load = 1'b1; bus.value = 16'h1234;
    step(1);
    bus.load = 1'b0;
    step(5);
    do_reset();
    step(26);
    check("drop_an",   bus.an, 4'b1110);
    check("drop_nib",  bus.nibble, 4'h0);
    check("drop_acks", ack_cnt, 0);
    step(6);
    check("drop_d1_an",  bus.an, 4'b1101);
    check("drop_d1_nib", bus.nibble, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
